// File: rtl/pixel_pkg.sv
// Shared pixel-pipeline constants and helpers for the filter and output stages.
// Used by pixel_stream_fifo (optional macro: PIXEL_FIFO_DROP_CNT_EN).
package pixel_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_IMG_W  = 512;
  localparam int DEF_IMG_H  = 512;
  localparam int DROP_W     = 16;

  // Ceiling log2, never below 1 so derived vectors stay legal.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/pixel_fifo_ram.sv
// Dual-port pixel storage: synchronous write, asynchronous read for FWFT.
// Part of pixel_stream_fifo (optional macro: PIXEL_FIFO_DROP_CNT_EN).
module pixel_fifo_ram
  import pixel_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = 64,
  parameter int AW     = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/pixel_stream_fifo.sv
// Streaming pixel FIFO with frame tracking, prog_full and drop reporting.
// Optional macro: PIXEL_FIFO_DROP_CNT_EN builds the saturating drop counter.
module pixel_stream_fifo
  import pixel_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DEPTH     = 64,
  parameter int PROG_FULL = 56,
  parameter int IMG_W     = DEF_IMG_W,
  parameter int IMG_H     = DEF_IMG_H
) (
  input  logic                   axi_clk,
  input  logic                   axi_rst,
  input  logic                   s_valid,
  input  logic [DATA_W-1:0]      s_data,
  output logic                   s_ready,
  output logic                   m_valid,
  output logic [DATA_W-1:0]      m_data,
  input  logic                   m_ready,
  output logic                   m_last,
  output logic                   m_user,
  output logic                   prog_full,
  output logic [clog2(DEPTH):0]  level,
  output logic                   overflow,
  output logic                   frame_intr,
  output logic [DROP_W-1:0]      drop_count
);

  localparam int AW = clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = clog2(IMG_W);
  localparam int RW = clog2(IMG_H);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_PF   = LW'(PROG_FULL);
  localparam logic [CW-1:0] COL_MAX  = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_MAX  = RW'(IMG_H - 1);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          s_ready_q, s_ready_d;
  logic          prog_full_q, prog_full_d;
  logic          overflow_q, overflow_d;
  logic          intr_q, intr_d;
  logic          full, wr, rd, drop;
  logic [DATA_W-1:0] rd_data;

  pixel_fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk     (axi_clk),
    .wr_en   (wr),
    .wr_addr (wr_ptr_q),
    .wr_data (s_data),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_data)
  );

  assign m_valid = level_q != '0;

  always_comb begin
    full        = level_q == LVL_FULL;
    wr          = s_valid && !full;
    drop        = s_valid && full;
    rd          = m_valid && m_ready;
    wr_ptr_d    = wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d    = rd ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d     = level_q;
    unique case ({wr, rd})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    col_d = col_q;
    row_d = row_q;
    if (rd) begin
      if (col_q == COL_MAX) begin
        col_d = '0;
        row_d = (row_q == ROW_MAX) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
    intr_d      = rd && col_q == COL_MAX && row_q == ROW_MAX;
    s_ready_d   = level_d != LVL_FULL;
    prog_full_d = level_d >= LVL_PF;
    overflow_d  = overflow_q || drop;
  end

  always_ff @(posedge axi_clk) begin
    if (axi_rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      col_q       <= '0;
      row_q       <= '0;
      s_ready_q   <= 1'b0;
      prog_full_q <= 1'b0;
      overflow_q  <= 1'b0;
      intr_q      <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      col_q       <= col_d;
      row_q       <= row_d;
      s_ready_q   <= s_ready_d;
      prog_full_q <= prog_full_d;
      overflow_q  <= overflow_d;
      intr_q      <= intr_d;
    end
  end

`ifdef PIXEL_FIFO_DROP_CNT_EN
  logic [DROP_W-1:0] drop_q, drop_d;

  always_comb begin
    drop_d = drop_q;
    if (drop && drop_q != '1) drop_d = drop_q + DROP_W'(1);
  end

  always_ff @(posedge axi_clk) begin
    if (axi_rst) drop_q <= '0;
    else         drop_q <= drop_d;
  end

  assign drop_count = drop_q;
`else
  assign drop_count = '0;
`endif

  // Gate with m_valid so an empty FIFO never exposes stale RAM contents.
  assign m_data     = m_valid ? rd_data : '0;
  assign m_last     = m_valid && col_q == COL_MAX;
  assign m_user     = m_valid && col_q == '0 && row_q == '0;
  assign s_ready    = s_ready_q;
  assign prog_full  = prog_full_q;
  assign level      = level_q;
  assign overflow   = overflow_q;
  assign frame_intr = intr_q;

endmodule

// File: tb/tb_pixel_stream_fifo.sv
// Directed bench for pixel_stream_fifo with a queue scoreboard and cycle model.
// Honours PIXEL_FIFO_DROP_CNT_EN when predicting drop_count.
module tb_pixel_stream_fifo;

  localparam int DEPTH = 64;
  localparam int PF    = 56;
  localparam int W     = 4;
  localparam int H     = 2;
`ifdef PIXEL_FIFO_DROP_CNT_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  logic       clk;
  logic       axi_rst;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_ready;
  logic       m_last;
  logic       m_user;
  logic       prog_full;
  logic [6:0] level;
  logic       overflow;
  logic       frame_intr;
  logic [15:0] drop_count;

  int checks = 0;
  int failures = 0;

  pixel_stream_fifo #(
    .DATA_W    (8),
    .DEPTH     (DEPTH),
    .PROG_FULL (PF),
    .IMG_W     (W),
    .IMG_H     (H)
  ) dut (
    .axi_clk    (clk),
    .axi_rst    (axi_rst),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_ready    (m_ready),
    .m_last     (m_last),
    .m_user     (m_user),
    .prog_full  (prog_full),
    .level      (level),
    .overflow   (overflow),
    .frame_intr (frame_intr),
    .drop_count (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard / cycle model: compares state, then predicts the next edge.
  logic [7:0] q[$];
  int  mcol = 0, mrow = 0, mdrop = 0;
  bit  movf = 0, mintr = 0, msrdy = 0, armed = 0;

  always @(negedge clk) begin
    bit rd, wr, full;
    if (armed) begin
      cmp("m_valid", m_valid, q.size() != 0);
      cmp("level", level, q.size());
      cmp("s_ready", s_ready, msrdy);
      cmp("prog_full", prog_full, q.size() >= PF);
      cmp("overflow", overflow, movf);
      cmp("drop_count", drop_count, mdrop);
      cmp("frame_intr", frame_intr, mintr);
      cmp("m_data", m_data, (q.size() != 0) ? q[0] : 8'h00);
      cmp("m_user", m_user, q.size() != 0 && mcol == 0 && mrow == 0);
      cmp("m_last", m_last, q.size() != 0 && mcol == W - 1);
    end
    if (axi_rst) begin
      q.delete();
      mcol = 0; mrow = 0; mdrop = 0;
      movf = 0; mintr = 0; msrdy = 0;
      armed = 1;
    end else if (armed) begin
      full  = q.size() == DEPTH;
      rd    = m_ready && q.size() != 0;
      wr    = s_valid && !full;
      mintr = rd && mcol == W - 1 && mrow == H - 1;
      if (s_valid && full) begin
        movf = 1;
        if (DROP_EN && mdrop < 16'hFFFF) mdrop++;
      end
      if (rd) begin
        void'(q.pop_front());
        if (mcol == W - 1) begin
          mcol = 0;
          mrow = (mrow == H - 1) ? 0 : mrow + 1;
        end else begin
          mcol++;
        end
      end
      if (wr) q.push_back(s_data);
      msrdy = q.size() != DEPTH;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    axi_rst = 1'b1;
    s_valid = 1'b0;
    s_data  = 8'h00;
    m_ready = 1'b0;
    cyc(3);
    cmp("rst_s_ready", s_ready, 0);
    cmp("rst_level", level, 0);
    cmp("rst_m_valid", m_valid, 0);
    axi_rst = 1'b0;
    cyc(1);
    cmp("post_rst_s_ready", s_ready, 1);

    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1;
      s_data  = 8'(8'h11 + i);
      cyc(1);
    end
    s_valid = 1'b0;
    cyc(2);
    cmp("hold_level", level, 4);
    cmp("hold_m_valid", m_valid, 1);
    cmp("hold_m_data", m_data, 8'h11);
    cyc(1);
    cmp("hold_m_data_2", m_data, 8'h11);
    m_ready = 1'b1;
    cyc(4);
    m_ready = 1'b0;
    cmp("drain_level", level, 0);

    for (int i = 0; i < DEPTH; i++) begin
      s_valid = 1'b1;
      s_data  = 8'(i);
      cyc(1);
      if (i == PF - 2) cmp("pf_before", prog_full, 0);
      if (i == PF - 1) cmp("pf_at", prog_full, 1);
    end
    cmp("full_s_ready", s_ready, 0);
    cmp("full_level", level, DEPTH);

    s_data = 8'hEE;
    cyc(3);
    s_valid = 1'b0;
    cyc(1);
    cmp("ovf_flag", overflow, 1);
    cmp("ovf_drop", drop_count, DROP_EN ? 3 : 0);
    cmp("ovf_level", level, DEPTH);

    s_valid = 1'b1;
    s_data  = 8'hDD;
    m_ready = 1'b1;
    cyc(1);
    s_valid = 1'b0;
    m_ready = 1'b0;
    cmp("rw_full_level", level, DEPTH - 1);
    m_ready = 1'b1;
    cyc(DEPTH - 1);
    cmp("drained", level, 0);

    axi_rst = 1'b1;
    cyc(2);
    cmp("rst2_overflow", overflow, 0);
    cmp("rst2_drop", drop_count, 0);
    axi_rst = 1'b0;
    cyc(1);

    for (int i = 0; i < 10; i++) begin
      s_valid = i < 9;
      s_data  = 8'(8'h40 + i);
      cyc(1);
      if (i < 9) begin
        cmp("frm_user", m_user, i == 0 || i == 8);
        cmp("frm_last", m_last, i == 3 || i == 7);
      end
      cmp("frm_intr", frame_intr, i == 8);
    end
    m_ready = 1'b0;

    for (int i = 0; i < 8; i++) begin
      s_valid = 1'b1;
      s_data  = 8'(8'h60 + i);
      cyc(1);
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    cyc(5);
    m_ready = 1'b0;
    axi_rst = 1'b1;
    cyc(1);
    cmp("mid_rst_level", level, 0);
    cmp("mid_rst_m_valid", m_valid, 0);
    cmp("mid_rst_s_ready", s_ready, 0);
    cmp("mid_rst_intr", frame_intr, 0);
    axi_rst = 1'b0;
    cyc(1);
    s_valid = 1'b1;
    s_data  = 8'h77;
    cyc(1);
    s_valid = 1'b0;
    cmp("after_rst_user", m_user, 1);
    cmp("after_rst_data", m_data, 8'h77);
    m_ready = 1'b1;
    cyc(1);
    m_ready = 1'b0;
    cyc(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pixel_stream_fifo.md
# pixel_stream_fifo

Parametrised streaming pixel buffer with frame tracking. It replaces the fixed 8-bit vendor output FIFO that sits between the filter stage (Gaussian blur and later Canny stages) and the AXI-Stream master port. It buffers filtered pixels, provides a programmable-full back-pressure signal to the upstream pixel controller, and marks line and frame boundaries (`m_last`, `m_user`). It also raises a one-cycle interrupt at the end of each frame and reports pixels lost when the producer ignores `s_ready`.

## Interface
- `DATA_W`, default 8: pixel width in bits.
- `DEPTH`, default 64: FIFO entries; power of two, ≥4.
- `PROG_FULL`, default 56: `prog_full` threshold in entries; range 1..DEPTH.
- `IMG_W`, default 512: pixels per line.
- `IMG_H`, default 512: lines per frame.

Ports:
- `axi_clk` in, 1: sole clock, rising edge.
- `axi_rst` in, 1: reset; synchronous, active-high.
- `s_valid` in, 1: input pixel valid.
- `s_data` in, DATA_W: input pixel.
- `s_ready` out, 1: FIFO not full.
- `m_valid` out, 1: output pixel valid.
- `m_data` out, DATA_W: output pixel.
- `m_ready` in, 1: downstream accepts.
- `m_last` out, 1: `m_data` is the last pixel of a line.
- `m_user` out, 1: `m_data` is the first pixel of a frame.
- `prog_full` out, 1: level ≥ PROG_FULL; drives upstream throttle.
- `level` out, clog2(DEPTH)+1: current occupancy.
- `overflow` out, 1: sticky; a write was attempted while full.
- `frame_intr` out, 1: one-cycle end-of-frame pulse.
- `drop_count` out, 16: dropped-pixel count (see Configuration).

## Operation
- Write happens when `s_valid && !full`. A write attempted while `s_valid && full` discards the pixel, sets `overflow`, and increments `drop_count` (saturates at 0xFFFF).
- Read happens when `m_valid && m_ready`.
- Simultaneous read and write: both occur and `level` is unchanged.
- Full is judged on the registered `level == DEPTH`. A write while full is dropped even if a read happens in the same cycle.
- Pointers are clog2(DEPTH) bits wide and wrap naturally; `level` is a separate up/down counter.
- Output is first-word-fall-through: `m_data` holds the head entry whenever `m_valid=1`. `m_data` holds stable while `m_valid && !m_ready`.
- Output-side position counters `col` (0..IMG_W-1) and `row` (0..IMG_H-1) advance only on a read:
  - `col` wraps to 0 after IMG_W-1 and increments `row`.
  - `row` wraps to 0 after IMG_H-1.
- `m_last = m_valid && col==IMG_W-1`.
- `m_user = m_valid && col==0 && row==0`.
- `frame_intr` is asserted for exactly the one cycle after the read of pixel (IMG_W-1, IMG_H-1).
- `overflow` clears only on reset.
- Reset mid-operation: FIFO contents are discarded, pointers, `level`, `col`, `row`, `overflow` and `drop_count` go to 0, and no `frame_intr` is produced for the partial frame.

## Timing
- Reset values: `s_ready=0` during reset, then 1 in the first cycle after reset deasserts.
- Also at reset: `m_valid=0`, `m_last=0`, `m_user=0`, `prog_full=0`, `level=0`, `overflow=0`, `frame_intr=0`, `drop_count=0`. `m_data` is 0.
- Write-to-output latency is 1 cycle: a write in cycle N into an empty FIFO gives `m_valid=1` in cycle N+1.
- `s_ready`, `prog_full` and `level` are registered and reflect state after cycle N's handshakes from cycle N+1.
- Full throughput: one pixel per cycle in and out with `m_ready` held high.
- PROG_FULL=DEPTH makes `prog_full` equivalent to full.

## Configuration
- `PIXEL_FIFO_DROP_CNT_EN` defined: the 16-bit saturating `drop_count` register is built.
- Undefined: `drop_count` is tied to 0 and no counter logic is built. `overflow` is present in both builds.

## Structure
- Package `pixel_pkg` holds:
  - default DATA_W, IMG_W and IMG_H constants shared with the controller and blur stages;
  - the `clog2` width function;
  - the drop-counter width constant (16).
- Sub-module `pixel_fifo_ram` provides the dual-port storage (DEPTH×DATA_W): synchronous write, and a read path giving FWFT behaviour.
- The top level holds pointers, level, flags, position counters and interrupt.

## Test plan
- Reset, then 4 writes of 0x11..0x14 with `m_ready=0` → `level=4`, `m_valid=1`, `m_data=0x11` stable. Then `m_ready=1` → 0x11..0x14 out on consecutive cycles.
- DEPTH=64, PROG_FULL=56, 56 writes with no reads → `prog_full=1` the cycle after the 56th write. 64 writes → `s_ready=0`.
- Full FIFO with `s_valid=1` for 3 cycles and no reads → `overflow=1`, `drop_count=3` (macro on) or 0 (macro off), `level=64`.
- Full FIFO, simultaneous read and write → read proceeds, write dropped, `level=63` next cycle.
- IMG_W=4, IMG_H=2, streaming 8 pixels → `m_user` on pixel 0, `m_last` on pixels 3 and 7, `frame_intr` one cycle after pixel 7. The next pixel gets `m_user` again.
- Assert reset after 5 of 8 pixels are read → all outputs at reset values, and the next read pixel carries `m_user=1`.
